// File: rtl/read_burst_capture.sv
// -----------------------------------------------------------------------------
// read_burst_capture
//   Captures a DDR5 read burst (BL8 or BL16) one DQ beat per clock after the
//   upstream preamble detector fires. It packs BEATS_PER_WORD beats per output
//   word, then holds off for a 1- or 2-cycle postamble before accepting the
//   next burst.
//
//   Optional feature: define READ_DBI_EN to add the active-low DBI_AD input.
//   A beat sampled with DBI_AD=0 is bitwise inverted before it is packed.
//
// Ports
//   clk_i              single clock, rising edge
//   reset_n_i          synchronous active-low reset (takes priority over en_i)
//   en_i               block enable; low forces IDLE and clears valid/last/err
//   pattern_detected_i preamble-found pulse; starts a burst from IDLE
//   DQ_AD              read data beat (DQ_W bits)
//   DBI_AD             active-low data-bus-inversion flag (READ_DBI_EN only)
//   burst_len_i        0 = BL8, 1 = BL16 (latched at burst start)
//   post_amble_sett_i  0 = 1-cycle, 1 = 2-cycle postamble (sampled on exit)
//   rd_data_o          packed word, beat 0 in the LSBs, held between pulses
//   rd_valid_o         one-cycle word-valid pulse
//   rd_last_o          high with rd_valid_o on the final word of a burst
//   busy_o             state is not IDLE
//   err_o              sticky: preamble pulse seen while not IDLE
// -----------------------------------------------------------------------------
module read_burst_capture #(
    parameter int DQ_W           = 8,
    parameter int BEATS_PER_WORD = 8
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           en_i,
    input  logic                           pattern_detected_i,
    input  logic [DQ_W-1:0]                DQ_AD,
`ifdef READ_DBI_EN
    input  logic                           DBI_AD,
`endif
    input  logic                           burst_len_i,
    input  logic                           post_amble_sett_i,
    output logic [DQ_W*BEATS_PER_WORD-1:0] rd_data_o,
    output logic                           rd_valid_o,
    output logic                           rd_last_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int WP_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAPTURE   = 2'd1,
        POSTAMBLE = 2'd2
    } state_e;

    typedef logic [BEATS_PER_WORD-1:0][DQ_W-1:0] word_t;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;       // beat index within the burst
    logic [WP_W-1:0]  wpos_q, wpos_d;     // beat slot within the current word
    logic             bl16_q, bl16_d;
    logic             pst_q, pst_d;       // one extra postamble cycle pending
    word_t            word_q, word_d;     // partial word being assembled
    word_t            rd_data_q, rd_data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [DQ_W-1:0]  beat;
    logic             last_beat;
    logic             word_full;

`ifdef READ_DBI_EN
    // DBI is active low: the sender inverted this beat, undo it.
    assign beat = DBI_AD ? DQ_AD : ~DQ_AD;
`else
    assign beat = DQ_AD;
`endif

    assign last_beat = (cnt_q == (bl16_q ? 4'd15 : 4'd7));
    assign word_full = (wpos_q == WP_W'(BEATS_PER_WORD - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wpos_d    = wpos_q;
        bl16_d    = bl16_q;
        pst_d     = pst_q;
        word_d    = word_q;
        rd_data_d = rd_data_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        err_d     = err_q;

        if (!en_i) begin
            // Abort: drop any partial word, keep the last delivered word.
            state_d = IDLE;
            cnt_d   = '0;
            wpos_d  = '0;
            pst_d   = 1'b0;
            word_d  = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pattern_detected_i) begin
                        bl16_d  = burst_len_i;
                        cnt_d   = '0;
                        wpos_d  = '0;
                        word_d  = '0;
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (pattern_detected_i) err_d = 1'b1;
                    word_d[wpos_q] = beat;
                    // Emit on a full word; also on the final beat so a burst
                    // never leaves a stranded partial word.
                    if (word_full || last_beat) begin
                        rd_data_d = word_d;
                        valid_d   = 1'b1;
                        last_d    = last_beat;
                        wpos_d    = '0;
                        word_d    = '0;
                    end else begin
                        wpos_d = wpos_q + 1'b1;
                    end
                    if (last_beat) begin
                        state_d = POSTAMBLE;
                        pst_d   = post_amble_sett_i;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                POSTAMBLE: begin
                    // A pulse on the edge returning to IDLE still lands here,
                    // so it is flagged rather than starting a burst.
                    if (pattern_detected_i) err_d = 1'b1;
                    if (pst_q) pst_d = 1'b0;
                    else       state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wpos_q    <= '0;
            bl16_q    <= 1'b0;
            pst_q     <= 1'b0;
            word_q    <= '0;
            rd_data_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wpos_q    <= wpos_d;
            bl16_q    <= bl16_d;
            pst_q     <= pst_d;
            word_q    <= word_d;
            rd_data_q <= rd_data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = valid_q;
    assign rd_last_o  = last_q;
    assign busy_o     = (state_q != IDLE);
    assign err_o      = err_q;

endmodule

// File: tb/tb_read_burst_capture.sv
// Directed bench for read_burst_capture (default parameters, 64-bit word).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point,
// so each sample shows what the preceding edge registered.
module tb_read_burst_capture;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        en_i;
    logic        pattern_detected_i;
    logic [7:0]  DQ_AD;
    logic        DBI_AD;
    logic        burst_len_i;
    logic        post_amble_sett_i;
    logic [63:0] rd_data_o;
    logic        rd_valid_o;
    logic        rd_last_o;
    logic        busy_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    logic seen_valid;

    read_burst_capture #(.DQ_W(8), .BEATS_PER_WORD(8)) dut (
        .clk_i              (clk_i),
        .reset_n_i          (reset_n_i),
        .en_i               (en_i),
        .pattern_detected_i (pattern_detected_i),
        .DQ_AD              (DQ_AD),
`ifdef READ_DBI_EN
        .DBI_AD             (DBI_AD),
`endif
        .burst_len_i        (burst_len_i),
        .post_amble_sett_i  (post_amble_sett_i),
        .rd_data_o          (rd_data_o),
        .rd_valid_o         (rd_valid_o),
        .rd_last_o          (rd_last_o),
        .busy_o             (busy_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, clock it, settle.
    task automatic step(input logic pd, input logic [7:0] dq);
        pattern_detected_i = pd;
        DQ_AD              = dq;
        @(posedge clk_i);
        #1;
        if (rd_valid_o) seen_valid = 1'b1;
    endtask

    initial begin
        reset_n_i = 1'b0; en_i = 1'b1; pattern_detected_i = 1'b0; DQ_AD = '0;
        DBI_AD = 1'b1; burst_len_i = 1'b0; post_amble_sett_i = 1'b0;
        seen_valid = 1'b0;
        step(0, 0); step(0, 0);
        chk("rst_data",  rd_data_o,  64'h0);
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_last",  rd_last_o,  0);
        chk("rst_busy",  busy_o,     0);
        chk("rst_err",   err_o,      0);
        reset_n_i = 1'b1;
        step(0, 0);

        // BL8, 1-cycle postamble
        burst_len_i = 0; post_amble_sett_i = 0;
        step(1, 0);
        chk("bl8_busy_start", busy_o, 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 8'(i));
            if (i == 7) chk("bl8_no_early_valid", rd_valid_o, 0);
        end
        chk("bl8_valid", rd_valid_o, 1);
        chk("bl8_last",  rd_last_o,  1);
        chk("bl8_data",  rd_data_o,  64'h0807060504030201);
        chk("bl8_busy_post", busy_o, 1);
        step(0, 8'hEE);
        chk("bl8_valid_pulse", rd_valid_o, 0);
        chk("bl8_data_hold",   rd_data_o,  64'h0807060504030201);
        chk("bl8_busy_idle",   busy_o,     0);
        chk("bl8_err",         err_o,      0);

        // BL16, 2-cycle postamble
        burst_len_i = 1; post_amble_sett_i = 1;
        step(1, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'(8'h10 + i));
            if (i == 7) begin
                chk("bl16_w0_valid", rd_valid_o, 1);
                chk("bl16_w0_last",  rd_last_o,  0);
                chk("bl16_w0_data",  rd_data_o,  64'h1716151413121110);
            end
            if (i == 8) chk("bl16_mid_valid", rd_valid_o, 0);
        end
        chk("bl16_w1_valid", rd_valid_o, 1);
        chk("bl16_w1_last",  rd_last_o,  1);
        chk("bl16_w1_data",  rd_data_o,  64'h1F1E1D1C1B1A1918);
        step(0, 0);
        chk("bl16_post2_busy", busy_o, 1);
        step(0, 0);
        chk("bl16_idle_busy", busy_o, 0);

        // Extra preamble pulse at N+5 of a BL8 burst
        burst_len_i = 0; post_amble_sett_i = 0;
        step(1, 0);
        for (int i = 1; i <= 8; i++) step(i == 5, 8'(8'h20 + i));
        chk("err_burst_data", rd_data_o, 64'h2827262524232221);
        chk("err_burst_last", rd_last_o, 1);
        chk("err_set",        err_o,     1);
        step(0, 0); step(0, 0); step(0, 0);
        chk("err_sticky",     err_o,     1);
        en_i = 0; step(0, 0);
        chk("err_clr_en",     err_o,     0);
        chk("en0_data_hold",  rd_data_o, 64'h2827262524232221);
        en_i = 1; step(0, 0);

        // Pulse on the edge that returns POSTAMBLE to IDLE is ignored
        step(1, 0);
        for (int i = 1; i <= 8; i++) step(0, 8'(8'h30 + i));
        step(1, 0);
        chk("ret_edge_err",  err_o,  1);
        chk("ret_edge_busy", busy_o, 0);
        en_i = 0; step(0, 0); en_i = 1; step(0, 0);

        // Reset at N+4 of a BL16 burst
        burst_len_i = 1;
        step(1, 0);
        step(0, 8'h41); step(0, 8'h42); step(0, 8'h43);
        reset_n_i = 0; step(0, 8'h44);
        chk("mid_rst_data",  rd_data_o,  64'h0);
        chk("mid_rst_busy",  busy_o,     0);
        chk("mid_rst_valid", rd_valid_o, 0);
        reset_n_i = 1;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) step(0, 8'h55);
        chk("mid_rst_no_valid", seen_valid, 0);

        // en_i=0 at N+3 discards partial word, data holds
        burst_len_i = 0;
        step(1, 0);
        for (int i = 0; i < 8; i++) step(0, 8'(8'hA0 + i));
        chk("pre_en_data", rd_data_o, 64'hA7A6A5A4A3A2A1A0);
        step(0, 0);
        step(1, 0);
        step(0, 8'h01); step(0, 8'h02);
        en_i = 0; step(0, 8'h03);
        chk("en_abort_busy", busy_o,    0);
        chk("en_abort_data", rd_data_o, 64'hA7A6A5A4A3A2A1A0);
        en_i = 1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) step(0, 8'h04);
        chk("en_abort_no_valid", seen_valid, 0);
        chk("en_abort_hold",     rd_data_o,  64'hA7A6A5A4A3A2A1A0);

`ifdef READ_DBI_EN
        // DBI low on beat 3 inverts that beat only
        step(1, 0);
        for (int i = 0; i < 8; i++) begin
            DBI_AD = (i == 3) ? 1'b0 : 1'b1;
            step(0, 8'hFF);
        end
        DBI_AD = 1'b1;
        chk("dbi_data", rd_data_o, 64'hFFFFFFFF00FFFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/read_burst_capture.md
READ_BURST_CAPTURE -- requirements
Module: read_burst_capture

Interface
REQ-001 SHALL have parameter DQ_W, default 8, meaning DQ lanes per beat.
REQ-002 SHALL have parameter BEATS_PER_WORD, default 8, meaning beats packed per output word.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, synchronous active-low reset.
REQ-005 SHALL have port en_i, input, 1, block enable, active high.
REQ-006 SHALL have port pattern_detected_i, input, 1, single-cycle preamble-found pulse from the upstream preamble detector.
REQ-007 SHALL have port DQ_AD, input, DQ_W, read data beat from the DDR5 bus.
REQ-008 SHALL have port burst_len_i, input, 1, 0 = BL8, 1 = BL16.
REQ-009 SHALL have port post_amble_sett_i, input, 1, 0 = 1-cycle postamble, 1 = 2-cycle postamble.
REQ-010 SHALL have port rd_data_o, output, DQ_W*BEATS_PER_WORD, packed word; beat 0 in the LSBs.
REQ-011 SHALL have port rd_valid_o, output, 1, single-cycle word-valid pulse.
REQ-012 SHALL have port rd_last_o, output, 1, high with rd_valid_o on the final word of a burst.
REQ-013 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.
REQ-014 SHALL have port err_o, output, 1, sticky protocol-error flag.

Function
REQ-015 SHALL implement the states IDLE, CAPTURE and POSTAMBLE.
REQ-016 IDLE: when pattern_detected_i=1 at edge N, SHALL latch burst_len_i, clear the beat counter and go to CAPTURE.
REQ-017 CAPTURE: SHALL sample one DQ_AD beat per edge, N+1 through N+8 for BL8 and N+1 through N+16 for BL16.
REQ-018 Beat k of a word SHALL be placed at rd_data_o[k*DQ_W +: DQ_W].
REQ-019 At the edge sampling the 8th beat of a word, SHALL register the full word into rd_data_o and assert rd_valid_o for exactly one cycle, so rd_valid_o is high during the cycle after edges N+8 and N+16.
REQ-020 rd_last_o SHALL assert together with the final rd_valid_o of a burst, and SHALL otherwise be 0.
REQ-021 rd_data_o SHALL hold its value between valid pulses.
REQ-022 After the final beat, SHALL go to POSTAMBLE for 1 cycle (post_amble_sett_i=0) or 2 cycles (post_amble_sett_i=1), sampled when leaving CAPTURE, then return to IDLE.
REQ-023 pattern_detected_i in CAPTURE or POSTAMBLE SHALL be ignored and SHALL set err_o; capture of the current burst SHALL continue unaffected.
REQ-024 pattern_detected_i on the same edge as the return to IDLE SHALL be ignored and flagged as an error per REQ-023.
REQ-025 The beat counter SHALL be 4 bits, SHALL never wrap within a burst, and SHALL reset to 0 on burst start.
REQ-026 en_i=0 SHALL, on the next edge, force IDLE, clear rd_valid_o, rd_last_o and err_o, and discard any partial word; rd_data_o SHALL hold its value.
REQ-027 err_o SHALL clear only on reset or en_i=0.

Reset
REQ-028 reset_n_i=0 at a rising edge SHALL force IDLE and set rd_data_o=0, rd_valid_o=0, rd_last_o=0, busy_o=0, err_o=0 and the counter to 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst; no rd_valid_o SHALL follow from the aborted burst.
REQ-030 Reset SHALL take priority over en_i.

Configuration
REQ-031 Macro READ_DBI_EN defined: SHALL add port DBI_AD, input, 1, active-low DBI; a beat sampled with DBI_AD=0 SHALL be bitwise inverted before packing.
REQ-032 Macro READ_DBI_EN undefined: port DBI_AD SHALL be absent and beats SHALL be packed unmodified.

Verification
REQ-033 BL8: pulse at N, beats 0x01..0x08 -> single rd_valid_o with rd_last_o=1 after edge N+8, rd_data_o=0x0807060504030201.
REQ-034 BL16: beats 0x10..0x1F -> valid after N+8 with data 0x1716151413121110 and rd_last_o=0, then valid after N+16 with data 0x1F1E1D1C1B1A1918 and rd_last_o=1; busy_o falls after 2 POSTAMBLE cycles when post_amble_sett_i=1.
REQ-035 Extra pattern_detected_i at N+5 of a BL8 burst -> burst completes normally and err_o=1 stays high until en_i=0.
REQ-036 reset_n_i=0 at N+4 of a BL16 burst -> all outputs are 0 next cycle and no rd_valid_o follows.
REQ-037 READ_DBI_EN defined: BL8 with DQ_AD=0xFF and DBI_AD=0 on beat 3 only -> byte 3 of rd_data_o is 0x00, other bytes are 0xFF.
REQ-038 en_i=0 at N+3 -> IDLE next edge, no rd_valid_o, and rd_data_o keeps its prior value.
